usb_line_event_detect: RTL and testbench

USB_LINE_EVENT_DETECT -- requirements
Module: usb_line_event_detect

---
 rtl/usb_line_event_detect.sv | 170 +++++++++++++++++
 tb/tb_usb_line_event_detect.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_line_event_detect.sv
// USB full-speed line event detector: registered line state, EOP and bus-reset detection.
// Define USB_SUSPEND_RESUME_EN to add idle-J suspend tracking and K-resume detection.
module usb_line_event_detect #(
  parameter int unsigned EOP_MIN_SE0         = 3,
  parameter int unsigned J_WINDOW            = 2,
  parameter int unsigned RESET_SE0_CYCLES    = 120,
  parameter int unsigned SUSPEND_IDLE_CYCLES = 144000,
  parameter int unsigned RESUME_K_CYCLES     = 960
) (
  input  logic       clk48,
  input  logic       RST,
  input  logic       dataInP,
  input  logic       dataInN,
  output logic [1:0] line_state,
  output logic       eop,
  output logic       usb_reset,
  output logic       suspend,
  output logic       resume
);

  localparam int unsigned SE0_W  = $clog2(RESET_SE0_CYCLES + 1);
  localparam int unsigned WAIT_W = (J_WINDOW < 1) ? 1 : $clog2(J_WINDOW + 1);
  localparam logic [SE0_W-1:0]  SE0_MAX  = SE0_W'(RESET_SE0_CYCLES);
  localparam logic [SE0_W-1:0]  SE0_MIN  = SE0_W'(EOP_MIN_SE0);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(J_WINDOW);

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } line_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SE0_RUN,
    ST_WAIT_J
  } eop_state_t;

  if (EOP_MIN_SE0 < 1 || EOP_MIN_SE0 >= RESET_SE0_CYCLES ||
      SUSPEND_IDLE_CYCLES < 1 || RESUME_K_CYCLES < 1) begin : g_bad_cfg
    $error("usb_line_event_detect: inconsistent timing parameters");
  end

  line_t             line_now;
  logic              is_se0, is_j, is_k;
  line_t             line_state_q, line_state_d;
  logic [SE0_W-1:0]  se0_cnt_q, se0_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  eop_state_t        state_q, state_d;
  logic              eop_q, eop_d;
  logic              usb_reset_q, usb_reset_d;
  logic              run_qualifies;

  // {N,P} maps directly onto the line-state encoding: SE0=0, J=1, K=2, SE1=3.
  assign line_now = line_t'({dataInN, dataInP});
  assign is_se0   = (line_now == LS_SE0);
  assign is_j     = (line_now == LS_J);
  assign is_k     = (line_now == LS_K);

  assign line_state_d  = line_now;
  assign run_qualifies = (se0_cnt_q >= SE0_MIN) && (se0_cnt_q < SE0_MAX);
  assign usb_reset_d   = is_se0 && (se0_cnt_q == SE0_MAX);

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    se0_cnt_d = '0;
    if (is_se0) begin
      se0_cnt_d = (se0_cnt_q == SE0_MAX) ? se0_cnt_q : se0_cnt_q + 1'b1;
    end
  end

  // The sample that ends a qualifying SE0 run is judged by the WAIT_J rules at once,
  // so a J immediately after SE0 yields eop and each K uses one slot of the window.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    eop_d      = 1'b0;
    if (is_se0) begin
      state_d = ST_SE0_RUN;
    end else if (state_q == ST_WAIT_J || (state_q == ST_SE0_RUN && run_qualifies)) begin
      state_d = ST_IDLE;
      if (is_j) begin
        eop_d = 1'b1;
      end else if (is_k && wait_cnt_q < WAIT_MAX) begin
        state_d    = ST_WAIT_J;
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk48 or posedge RST) begin
    if (RST) begin
      line_state_q <= LS_J;
      se0_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      state_q      <= ST_IDLE;
      eop_q        <= 1'b0;
      usb_reset_q  <= 1'b0;
    end else begin
      line_state_q <= line_state_d;
      se0_cnt_q    <= se0_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      state_q      <= state_d;
      eop_q        <= eop_d;
      usb_reset_q  <= usb_reset_d;
    end
  end

  assign line_state = line_state_q;
  assign eop        = eop_q;
  assign usb_reset  = usb_reset_q;

`ifdef USB_SUSPEND_RESUME_EN
  localparam int unsigned IDLE_W = $clog2(SUSPEND_IDLE_CYCLES + 1);
  localparam int unsigned K_W    = $clog2(RESUME_K_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SUSPEND_IDLE_CYCLES);
  localparam logic [K_W-1:0]    K_MAX    = K_W'(RESUME_K_CYCLES);
  localparam logic [K_W-1:0]    K_LAST   = K_W'(RESUME_K_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [K_W-1:0]    k_cnt_q, k_cnt_d;
  logic              suspend_q, suspend_d;
  logic              resume_q, resume_d;

  // K while suspended is resume signalling and holds suspend; the J that follows it
  // finds idle_cnt cleared, so suspend drops on that sample.
  always_comb begin
    idle_cnt_d = '0;
    k_cnt_d    = '0;
    suspend_d  = 1'b0;
    resume_d   = 1'b0;
    if (is_j) begin
      idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
      suspend_d  = (idle_cnt_q == IDLE_MAX);
    end else if (is_k && suspend_q) begin
      suspend_d = 1'b1;
      k_cnt_d   = (k_cnt_q == K_MAX) ? k_cnt_q : k_cnt_q + 1'b1;
      resume_d  = (k_cnt_q == K_LAST);
    end
    if (usb_reset_d) begin
      suspend_d = 1'b0;
    end
  end

  always_ff @(posedge clk48 or posedge RST) begin
    if (RST) begin
      idle_cnt_q <= '0;
      k_cnt_q    <= '0;
      suspend_q  <= 1'b0;
      resume_q   <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      k_cnt_q    <= k_cnt_d;
      suspend_q  <= suspend_d;
      resume_q   <= resume_d;
    end
  end

  assign suspend = suspend_q;
  assign resume  = resume_q;
`else
  assign suspend = 1'b0;
  assign resume  = 1'b0;
`endif

endmodule

// File: tb/tb_usb_line_event_detect.sv
// Self-checking bench for usb_line_event_detect: directed vector table, hand sequences
// and randomized line activity compared against a history-based reference model.
`timescale 1ns/1ps
module tb_usb_line_event_detect;

  localparam int unsigned EOP_MIN = 3;
  localparam int unsigned JW      = 2;
  localparam int unsigned RST_CYC = 120;
  localparam int unsigned SUSP    = 300;
  localparam int unsigned RES_K   = 24;

  typedef enum logic [1:0] {C_SE0 = 2'd0, C_J = 2'd1, C_K = 2'd2, C_SE1 = 2'd3} cls_t;

  typedef struct packed {
    int unsigned se0_len;
    cls_t        mid_cls;
    int unsigned mid_len;
    int unsigned exp_eops;
    int unsigned exp_rst;
  } vec_t;

  logic       clk48 = 1'b0;
  logic       RST;
  logic       dataInP, dataInN;
  logic [1:0] line_state;
  logic       eop, usb_reset, suspend, resume;

  int errors = 0;
  int checks = 0;
  int eop_seen, rst_seen, res_seen;
  cls_t hist[$];

  usb_line_event_detect #(
    .EOP_MIN_SE0        (EOP_MIN),
    .J_WINDOW           (JW),
    .RESET_SE0_CYCLES   (RST_CYC),
    .SUSPEND_IDLE_CYCLES(SUSP),
    .RESUME_K_CYCLES    (RES_K)
  ) dut (
    .clk48     (clk48),
    .RST       (RST),
    .dataInP   (dataInP),
    .dataInN   (dataInN),
    .line_state(line_state),
    .eop       (eop),
    .usb_reset (usb_reset),
    .suspend   (suspend),
    .resume    (resume)
  );

  always #5 clk48 = ~clk48;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model over the sample history ----------------
  function automatic int unsigned run_len(input int idx, input cls_t c);
    int unsigned n = 0;
    while (idx >= 0 && hist[idx] == c) begin
      n++;
      idx--;
    end
    return n;
  endfunction

  // eop after sample t: J, preceded by at most JW K's, preceded by an SE0 run of
  // EOP_MIN..RST_CYC-1 samples.
  function automatic bit exp_eop(input int t);
    int i;
    int unsigned k, l;
    if (hist[t] != C_J) return 1'b0;
    i = t - 1;
    k = 0;
    while (i >= 0 && hist[i] == C_K) begin
      k++;
      i--;
    end
    if (k > JW) return 1'b0;
    l = run_len(i, C_SE0);
    return (l >= EOP_MIN) && (l < RST_CYC);
  endfunction

  function automatic bit exp_rst(input int t);
    return (hist[t] == C_SE0) && (run_len(t, C_SE0) >= RST_CYC + 1);
  endfunction

  function automatic bit exp_susp(input int t);
`ifdef USB_SUSPEND_RESUME_EN
    int i;
    if (hist[t] == C_J) return run_len(t, C_J) >= SUSP + 1;
    if (hist[t] == C_K) begin
      i = t - int'(run_len(t, C_K));
      return (i >= 0) && (hist[i] == C_J) && (run_len(i, C_J) >= SUSP + 1);
    end
    return 1'b0;
`else
    return (t < 0);
`endif
  endfunction

  function automatic bit exp_res(input int t);
`ifdef USB_SUSPEND_RESUME_EN
    int i;
    if (hist[t] != C_K || run_len(t, C_K) != RES_K) return 1'b0;
    i = t - int'(RES_K);
    return (i >= 0) && (hist[i] == C_J) && (run_len(i, C_J) >= SUSP + 1);
`else
    return (t < 0);
`endif
  endfunction

  // Called at a falling edge: drive one sample, let it be clocked, compare at next falling edge.
  task automatic step(input cls_t c);
    int t;
    dataInP = (c == C_J) || (c == C_SE1);
    dataInN = (c == C_K) || (c == C_SE1);
    @(posedge clk48);
    hist.push_back(c);
    t = hist.size() - 1;
    @(negedge clk48);
    check("line_state", 32'(line_state), 32'(c));
    check("eop", 32'(eop), 32'(exp_eop(t)));
    check("usb_reset", 32'(usb_reset), 32'(exp_rst(t)));
    check("suspend", 32'(suspend), 32'(exp_susp(t)));
    check("resume", 32'(resume), 32'(exp_res(t)));
    check("exclusive", 32'((eop && usb_reset) || (eop && resume) || (usb_reset && resume)), 32'd0);
    eop_seen += int'(eop);
    rst_seen += int'(usb_reset);
    res_seen += int'(resume);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_line_state"}, 32'(line_state), 32'(C_J));
    check({tag, "_eop"}, 32'(eop), 32'd0);
    check({tag, "_usb_reset"}, 32'(usb_reset), 32'd0);
    check({tag, "_suspend"}, 32'(suspend), 32'd0);
    check({tag, "_resume"}, 32'(resume), 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{se0_len: 4,   mid_cls: C_J,   mid_len: 0, exp_eops: 1, exp_rst: 0};
    vecs[1]  = '{se0_len: 2,   mid_cls: C_J,   mid_len: 0, exp_eops: 0, exp_rst: 0};
    vecs[2]  = '{se0_len: 3,   mid_cls: C_K,   mid_len: 1, exp_eops: 1, exp_rst: 0};
    vecs[3]  = '{se0_len: 3,   mid_cls: C_K,   mid_len: 2, exp_eops: 1, exp_rst: 0};
    vecs[4]  = '{se0_len: 3,   mid_cls: C_K,   mid_len: 3, exp_eops: 0, exp_rst: 0};
    vecs[5]  = '{se0_len: 3,   mid_cls: C_SE1, mid_len: 1, exp_eops: 0, exp_rst: 0};
    vecs[6]  = '{se0_len: 130, mid_cls: C_J,   mid_len: 0, exp_eops: 0, exp_rst: 10};
    vecs[7]  = '{se0_len: 120, mid_cls: C_J,   mid_len: 0, exp_eops: 0, exp_rst: 0};
    vecs[8]  = '{se0_len: 119, mid_cls: C_J,   mid_len: 0, exp_eops: 1, exp_rst: 0};
    vecs[9]  = '{se0_len: 121, mid_cls: C_J,   mid_len: 0, exp_eops: 0, exp_rst: 1};
    vecs[10] = '{se0_len: 100, mid_cls: C_SE1, mid_len: 1, exp_eops: 0, exp_rst: 0};
    vecs[11] = '{se0_len: 1,   mid_cls: C_J,   mid_len: 0, exp_eops: 0, exp_rst: 0};

    // Reset state
    RST = 1'b1;
    dataInP = 1'b0;
    dataInN = 1'b0;
    repeat (3) @(negedge clk48);
    check_idle_outputs("reset");
    RST = 1'b0;
    hist.delete();

    // Directed vector table
    for (int v = 0; v < 12; v++) begin
      repeat (3) step(C_J);
      eop_seen = 0;
      rst_seen = 0;
      repeat (vecs[v].se0_len) step(C_SE0);
      repeat (vecs[v].mid_len) step(vecs[v].mid_cls);
      repeat (4) step(C_J);
      check($sformatf("vec%0d_eop_count", v), 32'(eop_seen), vecs[v].exp_eops);
      check($sformatf("vec%0d_reset_cycles", v), 32'(rst_seen), vecs[v].exp_rst);
    end

    // eop exactly one cycle after the J sample, for one cycle only
    repeat (4) step(C_SE0);
    step(C_J);
    check("eop_on_first_j", 32'(eop), 32'd1);
    step(C_J);
    check("eop_one_cycle", 32'(eop), 32'd0);

    // usb_reset edges
    repeat (120) step(C_SE0);
    check("rst_not_at_120", 32'(usb_reset), 32'd0);
    step(C_SE0);
    check("rst_at_121", 32'(usb_reset), 32'd1);
    repeat (9) step(C_SE0);
    check("rst_held", 32'(usb_reset), 32'd1);
    step(C_J);
    check("rst_falls_after_j", 32'(usb_reset), 32'd0);
    check("rst_no_eop", 32'(eop), 32'd0);

    // SE1 inside the J window aborts the pending eop
    repeat (2) step(C_J);
    eop_seen = 0;
    repeat (3) step(C_SE0);
    step(C_K);
    step(C_SE1);
    repeat (3) step(C_J);
    check("se1_in_window_eop_count", 32'(eop_seen), 32'd0);

    // Reset asserted mid SE0 run
    repeat (60) step(C_SE0);
    RST = 1'b1;
    #1;
    check_idle_outputs("mid_rst_async");
    repeat (3) @(negedge clk48);
    check_idle_outputs("mid_rst_hold");
    RST = 1'b0;
    hist.delete();
    eop_seen = 0;
    step(C_J);
    check_idle_outputs("after_rst");
    repeat (3) step(C_SE0);
    step(C_J);
    check("after_rst_eop", 32'(eop), 32'd1);
    check("after_rst_eop_count", 32'(eop_seen), 32'd1);

    // Suspend / resume sequence
    res_seen = 0;
    repeat (SUSP + 5) step(C_J);
`ifdef USB_SUSPEND_RESUME_EN
    check("suspend_after_idle", 32'(suspend), 32'd1);
`else
    check("suspend_tied_low", 32'(suspend), 32'd0);
`endif
    repeat (RES_K + 5) step(C_K);
`ifdef USB_SUSPEND_RESUME_EN
    check("resume_pulses", 32'(res_seen), 32'd1);
    check("suspend_during_k", 32'(suspend), 32'd1);
`else
    check("resume_tied_low", 32'(res_seen), 32'd0);
`endif
    step(C_J);
    check("suspend_drops_on_j", 32'(suspend), 32'd0);
    step(C_J);

    // Randomized line activity
    for (int r = 0; r < 300; r++) begin
      cls_t c;
      int unsigned len;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      c = (sel < 4) ? C_SE0 : (sel < 7) ? C_J : (sel < 9) ? C_K : C_SE1;
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 19) == 0) begin
        case (c)
          C_SE0:   len = $urandom_range(RST_CYC - 3, RST_CYC + 6);
          C_J:     len = $urandom_range(SUSP - 3, SUSP + 8);
          C_K:     len = $urandom_range(RES_K - 3, RES_K + 3);
          default: len = 1;
        endcase
      end
      repeat (len) step(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
